// File: rtl/turbosound_pkg.sv
// turbosound_pkg: shared definitions for the multi-chip TurboSound wrapper.
//   CMD_SELECT_PREFIX : upper five bits of an address latch that selects a chip
//   CMD_MUTE_CFG      : address latch that arms the mute-mask load
//   mix_state_t       : sequential mixer states
//   sel_decode        : maps the low three bits of a select command to a chip index
//   ym_amp            : 4-bit channel volume to linear amplitude (~3 dB per step)
package turbosound_pkg;

  localparam logic [4:0] CMD_SELECT_PREFIX = 5'b11111;
  localparam logic [7:0] CMD_MUTE_CFG      = 8'hF7;

  typedef enum logic [1:0] {IDLE, ACC, OUT} mix_state_t;

  // The chip index field is right-aligned in the top of the 3-bit code space,
  // so the highest code always selects the last chip (0xFF -> chip N-1).
  // Returns {hit, index}; hit is low when the code is below the valid range.
  function automatic logic [3:0] sel_decode(input logic [2:0] code, input int num_chips);
    logic [2:0] base;
    base = 3'(8 - num_chips);
    sel_decode = {code >= base, 3'(code - base)};
  endfunction

  // Peak of 341 lets the 2A+B / 2C+B stereo sum reach exactly 1023.
  function automatic logic [8:0] ym_amp(input logic [3:0] vol);
    case (vol)
      4'd0:    ym_amp = 9'd0;
      4'd1:    ym_amp = 9'd3;
      4'd2:    ym_amp = 9'd4;
      4'd3:    ym_amp = 9'd5;
      4'd4:    ym_amp = 9'd8;
      4'd5:    ym_amp = 9'd11;
      4'd6:    ym_amp = 9'd15;
      4'd7:    ym_amp = 9'd21;
      4'd8:    ym_amp = 9'd30;
      4'd9:    ym_amp = 9'd43;
      4'd10:   ym_amp = 9'd60;
      4'd11:   ym_amp = 9'd85;
      4'd12:   ym_amp = 9'd121;
      4'd13:   ym_amp = 9'd171;
      4'd14:   ym_amp = 9'd241;
      default: ym_amp = 9'd341;
    endcase
  endfunction

endpackage

// File: rtl/psg_seq_mixer.sv
// psg_seq_mixer: sums NUM_CHIPS stereo chip outputs one chip per clock.
//   clk_i, rst_i         : clock, async active-high reset
//   ce_i                 : starts a mix when idle, ignored otherwise
//   chip_l_i, chip_r_i   : packed chip outputs, chip 0 in the low bits
//   mute_i               : per-chip mute, sampled as each chip is accumulated
//   audio_l_o, audio_r_o : registered mixed samples
//   valid_o              : one-clock pulse when the samples update
module psg_seq_mixer
  import turbosound_pkg::*;
#(
  parameter int NUM_CHIPS = 2,
  parameter int IN_W      = 10,
  parameter int OUT_W     = 11
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      ce_i,
  input  logic [NUM_CHIPS*IN_W-1:0] chip_l_i,
  input  logic [NUM_CHIPS*IN_W-1:0] chip_r_i,
  input  logic [NUM_CHIPS-1:0]      mute_i,
  output logic [OUT_W-1:0]          audio_l_o,
  output logic [OUT_W-1:0]          audio_r_o,
  output logic                      valid_o
);

  mix_state_t         state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [OUT_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [OUT_W-1:0]   audio_l_q, audio_l_d, audio_r_q, audio_r_d;
  logic               valid_q, valid_d;
  logic [8*IN_W-1:0]  chip_l8, chip_r8;
  logic [7:0]         mute8;
  logic [IN_W-1:0]    cur_l, cur_r;

  // Padding to eight slots keeps the 3-bit index in range for any chip count.
  assign chip_l8 = (8*IN_W)'(chip_l_i);
  assign chip_r8 = (8*IN_W)'(chip_r_i);
  assign mute8   = 8'(mute_i);
  assign cur_l   = mute8[idx_q] ? '0 : chip_l8[idx_q*IN_W +: IN_W];
  assign cur_r   = mute8[idx_q] ? '0 : chip_r8[idx_q*IN_W +: IN_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
      valid_q   <= valid_d;
    end
  end

  // Output and valid are registered together so the strobe marks the update.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    audio_l_d = audio_l_q;
    audio_r_d = audio_r_q;
    valid_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ce_i) begin
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = ACC;
        end
      end
      ACC: begin
        acc_l_d = acc_l_q + OUT_W'(cur_l);
        acc_r_d = acc_r_q + OUT_W'(cur_r);
        idx_d   = idx_q + 3'd1;
        if (idx_q == 3'(NUM_CHIPS - 1)) state_d = OUT;
      end
      OUT: begin
        audio_l_d = acc_l_q;
        audio_r_d = acc_r_q;
        valid_d   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign audio_l_o = audio_l_q;
  assign audio_r_o = audio_r_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/ym2149.sv
// ym2149: reduced YM2149 PSG core (register file, bus port, tone generators,
// fixed-volume channels with ACB stereo). Noise and envelope are not modelled;
// the noise term is treated as permanently high.
//   clk_i, rst_i        : clock, async active-high reset
//   ce_i                : PSG clock enable, advances tone counters
//   bdir_i, bc_i, di_i  : bus control and data (latch / write)
//   do_o                : read data of the latched register (0xFF if none)
//   audio_l_o/_r_o      : left = 2A+B, right = 2C+B
//   ioa_*/iob_*         : IO ports, inputs read back when reg 7 marks them input
module ym2149
  import turbosound_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          ce_i,
  input  logic          bdir_i,
  input  logic          bc_i,
  input  logic [7:0]    di_i,
  output logic [7:0]    do_o,
  output logic [AW-1:0] audio_l_o,
  output logic [AW-1:0] audio_r_o,
  input  logic [7:0]    ioa_i,
  output logic [7:0]    ioa_o,
  input  logic [7:0]    iob_i,
  output logic [7:0]    iob_o
);

  logic [7:0]  regs_q [16];
  logic [3:0]  addr_q;
  logic        addr_ok_q;
  logic [11:0] tone_cnt_q [3];
  logic [2:0]  tone_q;
  logic [8:0]  amp [3];
  logic [9:0]  sum_l, sum_r;

  // Addresses above 15 invalidate the latch so wrapper command codes are inert.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
      addr_q    <= '0;
      addr_ok_q <= 1'b0;
    end else if (bdir_i && bc_i) begin
      addr_q    <= di_i[3:0];
      addr_ok_q <= (di_i[7:4] == 4'h0);
    end else if (bdir_i && addr_ok_q) begin
      regs_q[addr_q] <= di_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < 3; c++) tone_cnt_q[c] <= '0;
      tone_q <= '0;
    end else if (ce_i) begin
      for (int c = 0; c < 3; c++) begin
        if (tone_cnt_q[c] >= {regs_q[2*c+1][3:0], regs_q[2*c]}) begin
          tone_cnt_q[c] <= '0;
          tone_q[c]     <= ~tone_q[c];
        end else begin
          tone_cnt_q[c] <= tone_cnt_q[c] + 12'd1;
        end
      end
    end
  end

  // A disabled tone leaves the channel held high, i.e. a DC level at its volume.
  always_comb begin
    for (int c = 0; c < 3; c++) begin
      amp[c] = (tone_q[c] | regs_q[7][c]) ? ym_amp(regs_q[8+c][3:0]) : 9'd0;
    end
    sum_l = {amp[0], 1'b0} + {1'b0, amp[1]};
    sum_r = {amp[2], 1'b0} + {1'b0, amp[1]};
  end

  always_comb begin
    do_o = 8'hFF;
    if (addr_ok_q) begin
      if (addr_q == 4'd14 && !regs_q[7][6])      do_o = ioa_i;
      else if (addr_q == 4'd15 && !regs_q[7][7]) do_o = iob_i;
      else                                       do_o = regs_q[addr_q];
    end
  end

  assign audio_l_o = AW'(sum_l);
  assign audio_r_o = AW'(sum_r);
  assign ioa_o     = regs_q[14];
  assign iob_o     = regs_q[15];

endmodule

// File: rtl/turbosound_multi.sv
// turbosound_multi: NUM_CHIPS YM2149 cores on one PSG bus with chip select,
// write-only mute mask and a sequential stereo mixer.
//   CLK, RESET          : clock, async active-high reset
//   CE                  : PSG clock enable, also starts a mix
//   BDIR, BC, DI        : shared PSG bus, routed to the selected chip only
//   DO                  : read data of the selected chip
//   AUDIO_L/R           : mixed samples, SAMPLE_VALID pulses on update
//   SEL                 : selected chip index
//   IOA/IOB in/out      : IO ports of the last chip
module turbosound_multi
  import turbosound_pkg::*;
#(
  parameter  int NUM_CHIPS = 2,
  parameter  int IN_W      = 10,
  localparam int OUT_W     = IN_W + $clog2(NUM_CHIPS)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic             BDIR,
  input  logic             BC,
  input  logic [7:0]       DI,
  output logic [7:0]       DO,
  output logic [OUT_W-1:0] AUDIO_L,
  output logic [OUT_W-1:0] AUDIO_R,
  output logic             SAMPLE_VALID,
  output logic [2:0]       SEL,
  input  logic [7:0]       IOA_in,
  output logic [7:0]       IOA_out,
  input  logic [7:0]       IOB_in,
  output logic [7:0]       IOB_out
);

  logic [2:0]                sel_q, sel_d;
  logic [NUM_CHIPS-1:0]      mute_q, mute_d;
  logic                      armed_q, armed_d;
  logic [3:0]                dec;
  logic [NUM_CHIPS*IN_W-1:0] chip_l, chip_r;
  logic [7:0]                do_all [8];

  // Any address latch disarms the mute load unless it is the arm code itself.
  always_comb begin
    sel_d   = sel_q;
    mute_d  = mute_q;
    armed_d = armed_q;
    dec     = sel_decode(DI[2:0], NUM_CHIPS);
    if (BDIR && BC) begin
      armed_d = (DI == CMD_MUTE_CFG);
      if (DI[7:3] == CMD_SELECT_PREFIX && dec[3]) sel_d = dec[2:0];
    end else if (BDIR && armed_q) begin
      mute_d  = DI[NUM_CHIPS-1:0];
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sel_q   <= 3'(NUM_CHIPS - 1);
      mute_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      mute_q  <= mute_d;
      armed_q <= armed_d;
    end
  end

  // Unused slots read as an idle bus so DO needs no range check on SEL.
  for (genvar g = 0; g < 8; g++) begin : g_slot
    if (g < NUM_CHIPS) begin : g_chip
      logic       hit;
      logic [7:0] ioa_in_w, iob_in_w, ioa_out_w, iob_out_w;
      assign hit      = (sel_q == 3'(g));
      assign ioa_in_w = (g == NUM_CHIPS - 1) ? IOA_in : 8'hFF;
      assign iob_in_w = (g == NUM_CHIPS - 1) ? IOB_in : 8'hFF;
      ym2149 #(.AW(IN_W)) u_psg (
        .clk_i     (CLK),
        .rst_i     (RESET),
        .ce_i      (CE),
        .bdir_i    (BDIR & hit),
        .bc_i      (BC & hit),
        .di_i      (DI),
        .do_o      (do_all[g]),
        .audio_l_o (chip_l[g*IN_W +: IN_W]),
        .audio_r_o (chip_r[g*IN_W +: IN_W]),
        .ioa_i     (ioa_in_w),
        .ioa_o     (ioa_out_w),
        .iob_i     (iob_in_w),
        .iob_o     (iob_out_w)
      );
      if (g == NUM_CHIPS - 1) begin : g_io
        assign IOA_out = ioa_out_w;
        assign IOB_out = iob_out_w;
      end
    end else begin : g_empty
      assign do_all[g] = 8'hFF;
    end
  end

  psg_seq_mixer #(.NUM_CHIPS(NUM_CHIPS), .IN_W(IN_W), .OUT_W(OUT_W)) u_mix (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .ce_i      (CE),
    .chip_l_i  (chip_l),
    .chip_r_i  (chip_r),
    .mute_i    (mute_q),
    .audio_l_o (AUDIO_L),
    .audio_r_o (AUDIO_R),
    .valid_o   (SAMPLE_VALID)
  );

  assign DO  = do_all[sel_q];
  assign SEL = sel_q;

endmodule
